// File: rtl/sys_array_lock_arbiter.sv
// Funnels per-thread LOAD/COMP lock requests into one requester per
// systolic-array channel, with round-robin grant, watchdog and error log.
//
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   load_lock_req, B_addr_in     per-thread LOAD request and B address
//   load_lock_res, load_finished one-hot LOAD grant, completion pulse
//   comp_lock_req, A/D/C_addr_in per-thread COMP request and addresses
//   comp_lock_res, comp_finished one-hot COMP grant, completion pulse
//   ctrl_load_*, ctrl_B_addr     LOAD handshake toward the controller
//   ctrl_comp_*, ctrl_A/D/C_addr COMP handshake toward the controller
//   err_valid/channel/thread     sticky record of the first timeout

module sys_array_lock_arbiter_chan #(
   parameter int NTHREADS       = 2,
   parameter int AW             = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int TW            = $clog2(NTHREADS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NTHREADS-1:0]    req,
   input  logic [NTHREADS*AW-1:0] addr_in,
   input  logic                   ack,
   input  logic                   done,
   output logic [NTHREADS-1:0]    lock_res,
   output logic [NTHREADS-1:0]    finished,
   output logic                   ctrl_req,
   output logic [AW-1:0]          addr,
   output logic                   tmo,
   output logic [TW-1:0]          owner
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_t;

   state_t         state, state_n;
   logic [TW-1:0]  ptr;
   logic [TW-1:0]  win;
   logic           found;
   int             idx;
   logic [CW-1:0]  cnt;
   logic           expire;
   logic [AW-1:0]  addr_q;

   // First requester at or above ptr, wrapping around.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NTHREADS; k++) begin
         idx = (int'(ptr) + k) % NTHREADS;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = TW'(idx);
         end
      end
   end

   // cnt holds the number of cycles already spent in REQ/BUSY.
   assign expire = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

   always_comb begin
      state_n = state;
      tmo     = 1'b0;
      unique case (state)
         IDLE: if (|req) state_n = REQ;
         REQ: begin
            if (ack && done) begin
               state_n = DONE;
            end else if (expire) begin
               state_n = DONE;
               tmo     = 1'b1;
            end else if (ack) begin
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (done) begin
               state_n = DONE;
            end else if (expire) begin
               state_n = DONE;
               tmo     = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && |req) begin
            owner  <= win;
            addr_q <= addr_in[int'(win)*AW +: AW];
            cnt    <= '0;
         end else if (state == REQ || state == BUSY) begin
            cnt <= cnt + 1'b1;
         end
         if (state == DONE) begin
            ptr <= (owner == TW'(NTHREADS - 1)) ? '0 : owner + 1'b1;
         end
      end
   end

   assign ctrl_req = (state == REQ);
   assign lock_res = (state != IDLE) ? NTHREADS'(1) << owner : '0;
   assign finished = (state == DONE) ? NTHREADS'(1) << owner : '0;
   assign addr     = addr_q;

endmodule

module sys_array_lock_arbiter #(
   parameter int BITWIDTH       = 32,
   parameter int NTHREADS       = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int TW            = $clog2(NTHREADS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NTHREADS-1:0]          load_lock_req,
   input  logic [NTHREADS*BITWIDTH-1:0] B_addr_in,
   output logic [NTHREADS-1:0]          load_lock_res,
   output logic [NTHREADS-1:0]          load_finished,
   input  logic [NTHREADS-1:0]          comp_lock_req,
   input  logic [NTHREADS*BITWIDTH-1:0] A_addr_in,
   input  logic [NTHREADS*BITWIDTH-1:0] D_addr_in,
   input  logic [NTHREADS*BITWIDTH-1:0] C_addr_in,
   output logic [NTHREADS-1:0]          comp_lock_res,
   output logic [NTHREADS-1:0]          comp_finished,
   output logic                         ctrl_load_req,
   input  logic                         ctrl_load_ack,
   input  logic                         ctrl_load_done,
   output logic [BITWIDTH-1:0]          ctrl_B_addr,
   output logic                         ctrl_comp_req,
   input  logic                         ctrl_comp_ack,
   input  logic                         ctrl_comp_done,
   output logic [BITWIDTH-1:0]          ctrl_A_addr,
   output logic [BITWIDTH-1:0]          ctrl_D_addr,
   output logic [BITWIDTH-1:0]          ctrl_C_addr,
   output logic                         err_valid,
   output logic                         err_channel,
   output logic [TW-1:0]                err_thread
);

   localparam int CAW = 3 * BITWIDTH;

   logic [NTHREADS*CAW-1:0] comp_addr_in;
   logic [CAW-1:0]          comp_addr;
   logic                    load_tmo, comp_tmo;
   logic [TW-1:0]           load_owner, comp_owner;

   // COMP carries A, D and C as one packed slice per thread.
   for (genvar i = 0; i < NTHREADS; i++) begin : g_pack
      assign comp_addr_in[i*CAW +: CAW] = {A_addr_in[i*BITWIDTH +: BITWIDTH],
                                           D_addr_in[i*BITWIDTH +: BITWIDTH],
                                           C_addr_in[i*BITWIDTH +: BITWIDTH]};
   end

   sys_array_lock_arbiter_chan #(
      .NTHREADS(NTHREADS), .AW(BITWIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_load (
      .clock(clock), .reset(reset),
      .req(load_lock_req), .addr_in(B_addr_in),
      .ack(ctrl_load_ack), .done(ctrl_load_done),
      .lock_res(load_lock_res), .finished(load_finished),
      .ctrl_req(ctrl_load_req), .addr(ctrl_B_addr),
      .tmo(load_tmo), .owner(load_owner)
   );

   sys_array_lock_arbiter_chan #(
      .NTHREADS(NTHREADS), .AW(CAW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_comp (
      .clock(clock), .reset(reset),
      .req(comp_lock_req), .addr_in(comp_addr_in),
      .ack(ctrl_comp_ack), .done(ctrl_comp_done),
      .lock_res(comp_lock_res), .finished(comp_finished),
      .ctrl_req(ctrl_comp_req), .addr(comp_addr),
      .tmo(comp_tmo), .owner(comp_owner)
   );

   assign {ctrl_A_addr, ctrl_D_addr, ctrl_C_addr} = comp_addr;

   // Only the first timeout is kept; LOAD wins a same-cycle tie.
   always_ff @(posedge clock) begin
      if (!reset) begin
         err_valid   <= 1'b0;
         err_channel <= 1'b0;
         err_thread  <= '0;
      end else if (!err_valid && (load_tmo || comp_tmo)) begin
         err_valid   <= 1'b1;
         err_channel <= !load_tmo;
         err_thread  <= load_tmo ? load_owner : comp_owner;
      end
   end

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// Directed self-checking bench for sys_array_lock_arbiter.
// Two threads, 32-bit addresses, watchdog limit of 8 cycles.

module tb_sys_array_lock_arbiter;

   localparam int BW = 32;
   localparam int NT = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [NT-1:0] load_lock_req, comp_lock_req;
   logic [NT*BW-1:0] B_addr_in, A_addr_in, D_addr_in, C_addr_in;
   logic [NT-1:0] load_lock_res, load_finished;
   logic [NT-1:0] comp_lock_res, comp_finished;
   logic          ctrl_load_req, ctrl_load_ack, ctrl_load_done;
   logic          ctrl_comp_req, ctrl_comp_ack, ctrl_comp_done;
   logic [BW-1:0] ctrl_B_addr, ctrl_A_addr, ctrl_D_addr, ctrl_C_addr;
   logic          err_valid, err_channel;
   logic [0:0]    err_thread;

   int checks = 0;
   int errors = 0;

   logic [NT-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   sys_array_lock_arbiter #(
      .BITWIDTH(BW), .NTHREADS(NT), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset),
      .load_lock_req(load_lock_req), .B_addr_in(B_addr_in),
      .load_lock_res(load_lock_res), .load_finished(load_finished),
      .comp_lock_req(comp_lock_req),
      .A_addr_in(A_addr_in), .D_addr_in(D_addr_in), .C_addr_in(C_addr_in),
      .comp_lock_res(comp_lock_res), .comp_finished(comp_finished),
      .ctrl_load_req(ctrl_load_req), .ctrl_load_ack(ctrl_load_ack),
      .ctrl_load_done(ctrl_load_done), .ctrl_B_addr(ctrl_B_addr),
      .ctrl_comp_req(ctrl_comp_req), .ctrl_comp_ack(ctrl_comp_ack),
      .ctrl_comp_done(ctrl_comp_done),
      .ctrl_A_addr(ctrl_A_addr), .ctrl_D_addr(ctrl_D_addr),
      .ctrl_C_addr(ctrl_C_addr),
      .err_valid(err_valid), .err_channel(err_channel),
      .err_thread(err_thread)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset          = 1'b0;
      load_lock_req  = 2'b11;
      comp_lock_req  = 2'b11;
      B_addr_in      = '0;
      A_addr_in      = '0;
      D_addr_in      = '0;
      C_addr_in      = '0;
      ctrl_load_ack  = 1'b0;
      ctrl_load_done = 1'b0;
      ctrl_comp_ack  = 1'b0;
      ctrl_comp_done = 1'b0;

      // Reset held with all requests high.
      tick(3);
      check("rst_load_res", 64'(load_lock_res), 0);
      check("rst_comp_res", 64'(comp_lock_res), 0);
      check("rst_load_req", 64'(ctrl_load_req), 0);
      check("rst_comp_req", 64'(ctrl_comp_req), 0);
      check("rst_err", 64'({err_valid, err_channel, err_thread}), 0);
      check("rst_fin", 64'({load_finished, comp_finished}), 0);
      reset = 1'b1;
      tick(1);
      check("post_rst_load", 64'(load_lock_res), 64'b01);
      check("post_rst_comp", 64'(comp_lock_res), 64'b01);
      load_lock_req  = '0;
      comp_lock_req  = '0;
      ctrl_load_ack  = 1'b1;
      ctrl_load_done = 1'b1;
      ctrl_comp_ack  = 1'b1;
      ctrl_comp_done = 1'b1;
      tick(1);
      ctrl_load_ack  = 1'b0;
      ctrl_load_done = 1'b0;
      ctrl_comp_ack  = 1'b0;
      ctrl_comp_done = 1'b0;
      check("ackdone_fin", 64'(load_finished), 64'b01);
      check("ackdone_res", 64'(load_lock_res), 64'b01);
      check("ackdone_cfin", 64'(comp_finished), 64'b01);
      tick(1);
      check("ackdone_idle", 64'({load_lock_res, comp_lock_res}), 0);

      // Single LOAD from thread 1, ack at +3, done at +6.
      load_lock_req = 2'b10;
      B_addr_in     = {32'h40, 32'h0};
      tick(1);
      check("ld_res", 64'(load_lock_res), 64'b10);
      check("ld_req", 64'(ctrl_load_req), 1);
      check("ld_baddr", 64'(ctrl_B_addr), 64'h40);
      load_lock_req = '0;
      B_addr_in     = {32'hdead, 32'hbeef};
      tick(1);
      check("ld_req_hold", 64'(ctrl_load_req), 1);
      tick(1);
      ctrl_load_ack = 1'b1;
      tick(1);
      ctrl_load_ack = 1'b0;
      check("ld_busy_req", 64'(ctrl_load_req), 0);
      check("ld_busy_res", 64'(load_lock_res), 64'b10);
      tick(2);
      ctrl_load_done = 1'b1;
      tick(1);
      ctrl_load_done = 1'b0;
      check("ld_fin", 64'(load_finished), 64'b10);
      check("ld_fin_res", 64'(load_lock_res), 64'b10);
      check("ld_baddr_stable", 64'(ctrl_B_addr), 64'h40);
      tick(1);
      check("ld_idle_res", 64'(load_lock_res), 0);
      check("ld_idle_fin", 64'(load_finished), 0);

      // Stray controller pulses while idle.
      ctrl_load_done = 1'b1;
      ctrl_load_ack  = 1'b1;
      tick(1);
      ctrl_load_done = 1'b0;
      ctrl_load_ack  = 1'b0;
      check("stray_res", 64'(load_lock_res), 0);
      check("stray_fin", 64'(load_finished), 0);
      check("stray_req", 64'(ctrl_load_req), 0);

      // Thread 0 owns LOAD while thread 1 owns COMP.
      load_lock_req = 2'b01;
      comp_lock_req = 2'b10;
      B_addr_in     = {32'h77, 32'h55};
      A_addr_in     = {32'h10, 32'h99};
      D_addr_in     = {32'h20, 32'h98};
      C_addr_in     = {32'h30, 32'h97};
      tick(1);
      check("cc_load_res", 64'(load_lock_res), 64'b01);
      check("cc_comp_res", 64'(comp_lock_res), 64'b10);
      check("cc_b", 64'(ctrl_B_addr), 64'h55);
      check("cc_adc", {16'h0, ctrl_A_addr[15:0], ctrl_D_addr[15:0],
                       ctrl_C_addr[15:0]}, 64'h0000_0010_0020_0030);
      B_addr_in     = '1;
      A_addr_in     = '1;
      D_addr_in     = '1;
      C_addr_in     = '1;
      ctrl_load_ack = 1'b1;
      ctrl_comp_ack = 1'b1;
      tick(1);
      ctrl_load_ack = 1'b0;
      ctrl_comp_ack = 1'b0;
      check("cc_a_stable", 64'(ctrl_A_addr), 64'h10);
      check("cc_c_stable", 64'(ctrl_C_addr), 64'h30);
      check("cc_b_stable", 64'(ctrl_B_addr), 64'h55);
      ctrl_load_done = 1'b1;
      ctrl_comp_done = 1'b1;
      tick(1);
      ctrl_load_done = 1'b0;
      ctrl_comp_done = 1'b0;
      load_lock_req  = '0;
      comp_lock_req  = '0;
      check("cc_fin", 64'({load_finished, comp_finished}), 64'b0110);
      check("cc_d_stable", 64'(ctrl_D_addr), 64'h20);
      tick(1);
      check("cc_idle", 64'({load_lock_res, comp_lock_res}), 0);

      // Round robin on COMP with both threads requesting.
      comp_lock_req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check($sformatf("rr_grant%0d", i), 64'(comp_lock_res), 64'(rr_exp[i]));
         ctrl_comp_ack  = 1'b1;
         ctrl_comp_done = 1'b1;
         tick(1);
         ctrl_comp_ack  = 1'b0;
         ctrl_comp_done = 1'b0;
         check($sformatf("rr_fin%0d", i), 64'(comp_finished), 64'(rr_exp[i]));
         tick(1);
         check($sformatf("rr_gap%0d", i), 64'(comp_lock_res), 0);
      end
      comp_lock_req = '0;
      tick(1);

      // COMP timeout for thread 1: acked, never done.
      comp_lock_req = 2'b10;
      tick(1);
      check("to_grant", 64'(comp_lock_res), 64'b10);
      comp_lock_req = '0;
      ctrl_comp_ack = 1'b1;
      tick(1);
      ctrl_comp_ack = 1'b0;
      tick(6);
      check("to_not_yet", 64'({comp_finished, comp_lock_res}), 64'b0010);
      check("to_no_err_yet", 64'(err_valid), 0);
      tick(1);
      check("to_fin", 64'(comp_finished), 64'b10);
      check("to_req_low", 64'(ctrl_comp_req), 0);
      check("to_err", 64'({err_valid, err_channel, err_thread}), 64'b111);
      tick(1);
      check("to_idle", 64'(comp_lock_res), 0);

      // Second timeout on LOAD from REQ must not overwrite the record.
      load_lock_req = 2'b01;
      tick(1);
      check("to2_grant", 64'(load_lock_res), 64'b01);
      load_lock_req = '0;
      tick(7);
      check("to2_not_yet", 64'(load_finished), 0);
      tick(1);
      check("to2_fin", 64'(load_finished), 64'b01);
      check("to2_req_low", 64'(ctrl_load_req), 0);
      check("to2_err_kept", 64'({err_valid, err_channel, err_thread}), 64'b111);
      tick(1);

      // Reset asserted while COMP is busy.
      comp_lock_req = 2'b01;
      A_addr_in     = {32'h0, 32'h1234};
      tick(1);
      check("rb_grant", 64'(comp_lock_res), 64'b01);
      check("rb_a", 64'(ctrl_A_addr), 64'h1234);
      comp_lock_req = '0;
      ctrl_comp_ack = 1'b1;
      tick(1);
      ctrl_comp_ack = 1'b0;
      reset         = 1'b0;
      tick(1);
      check("rb_res", 64'({comp_lock_res, comp_finished}), 0);
      check("rb_err", 64'({err_valid, err_channel, err_thread}), 0);
      check("rb_a_clr", 64'(ctrl_A_addr), 0);
      reset          = 1'b1;
      ctrl_comp_done = 1'b1;
      tick(1);
      ctrl_comp_done = 1'b0;
      check("rb_no_fin", 64'(comp_finished), 0);
      check("rb_no_res", 64'(comp_lock_res), 0);
      tick(1);
      check("rb_quiet", 64'({comp_finished, comp_lock_res, ctrl_comp_req}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sys_array_lock_arbiter.md
Name: sys_array_lock_arbiter

Overview:
Arbitrates the systolic-array LOAD and COMP resources between NTHREADS hardware threads. Each thread-side lock_req/lock_res pair with its address operands is funnelled into a single requester interface toward sys_array_controller, so the controller always sees exactly one owner per channel. Each channel has a round-robin grant pointer, a per-transaction watchdog and a sticky error report. The block sits in core between the threads and sys_array_controller.

Parameters:
BITWIDTH, 32, width of every address operand
NTHREADS, 2, number of requesting threads (>=2)
TIMEOUT_CYCLES, 4096, watchdog limit per transaction; 0 disables the watchdog

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
load_lock_req  in  NTHREADS  per-thread LOAD request (level)
B_addr_in  in  NTHREADS*BITWIDTH  per-thread B address; thread i occupies slice [i*BITWIDTH +: BITWIDTH]
load_lock_res  out  NTHREADS  one-hot LOAD grant
load_finished  out  NTHREADS  one-cycle completion pulse to the LOAD owner
comp_lock_req  in  NTHREADS  per-thread COMP request (level)
A_addr_in, D_addr_in, C_addr_in  in  NTHREADS*BITWIDTH each  per-thread COMP addresses, same slicing as B_addr_in
comp_lock_res  out  NTHREADS  one-hot COMP grant
comp_finished  out  NTHREADS  one-cycle completion pulse to the COMP owner
ctrl_load_req  out  1  LOAD request to the controller (level)
ctrl_load_ack  in  1  controller accepted the LOAD (pulse)
ctrl_load_done  in  1  controller finished the LOAD (pulse)
ctrl_B_addr  out  BITWIDTH  latched B address
ctrl_comp_req, ctrl_comp_ack, ctrl_comp_done  out/in/in  1  COMP equivalents
ctrl_A_addr, ctrl_D_addr, ctrl_C_addr  out  BITWIDTH  latched COMP addresses
err_valid  out  1  sticky flag: a watchdog timeout occurred
err_channel  out  1  channel of the first timeout (0 = LOAD, 1 = COMP)
err_thread  out  clog2(NTHREADS)  owner at the first timeout

Behaviour:
- The two channels are identical and fully independent. One thread may own LOAD and COMP at the same time.
- Reset (reset==0 at posedge) forces the following, including mid-transaction; no controller pulse is replayed:
  - Both FSMs go to IDLE and both pointers go to 0.
  - Every output is 0, including all address outputs and all err_* outputs.
- Per-channel FSM: IDLE -> REQ -> BUSY -> DONE -> IDLE.
- IDLE:
  - If any req bit is set at cycle t, select winner w: the first set bit scanning from ptr upward, modulo NTHREADS.
  - Latch w's address slice(s) at t.
  - At t+1 the FSM is in REQ, lock_res[w]=1 and ctrl_*_req=1.
  - Grant latency is therefore 1 cycle.
- REQ:
  - ctrl_*_req is held high until ctrl_*_ack is seen. On ack: go to BUSY and drop ctrl_*_req the next cycle.
  - ack and done in the same cycle: go directly to DONE.
- BUSY: wait for ctrl_*_done, then go to DONE.
- DONE (exactly one cycle):
  - *_finished[w]=1 and lock_res[w] is still 1.
  - ptr <= (w+1) mod NTHREADS.
  - Next cycle: IDLE with lock_res all zero. The earliest re-grant is the cycle after that, so there are at least 2 cycles between grants.
- Latched addresses are held stable from REQ through DONE and are unaffected by later input changes.
- The owner dropping its req during REQ/BUSY is ignored; the transaction completes normally.
- done/ack pulses outside REQ/BUSY are ignored. ack while in BUSY is ignored.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter clears on entry to REQ and increments every cycle in REQ/BUSY.
  - When it reaches TIMEOUT_CYCLES without done, go to DONE with ctrl_*_req forced to 0. The owner still gets its *_finished pulse.
  - The first timeout sets err_valid and captures err_channel/err_thread. Later timeouts do not overwrite them; only reset clears them.
  - LOAD and COMP timing out in the same cycle: LOAD is recorded.
- lock_res is always one-hot or zero. No two threads are ever granted the same channel.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all reqs high -> every output 0; after release, load_lock_res=01 one cycle later.
- Single LOAD: thread1 req with B_addr=0x40 -> next cycle load_lock_res=10, ctrl_load_req=1, ctrl_B_addr=0x40; ack at +3, done at +6 -> load_finished=10 at +7, lock_res=00 at +8.
- Round robin: both threads hold comp_lock_req=11 through 4 back-to-back transactions -> grant sequence 01,10,01,10 with ≥2 cycles between grants.
- Concurrency and stability: thread0 owns LOAD while thread1 owns COMP, A/D/C=0x10/0x20/0x30 -> both granted simultaneously; inputs change mid-transaction -> ctrl addresses stay latched.
- Timeout: TIMEOUT_CYCLES=8, ack but never done on COMP for thread1 -> comp_finished=10 exactly 8 cycles after REQ entry, err_valid=1, err_channel=1, err_thread=1; a second timeout leaves the err fields unchanged.
- Edge pulses: ack+done in the same cycle -> DONE next cycle; reset asserted in BUSY -> IDLE with no finished pulse; a stray done in IDLE -> no effect.
